distance_array: RTL and testbench

Multi-channel ultrasonic ranging front end. It fires N_CH HC-SR04-style sensors in round-robin order and times each echo pulse in prescaled ticks, with a per-measurement timeout. Each channel keeps a 2^AVG_LOG2-deep running average, which is mapped to a 4-bit proximity intensity. The block sits between the sensor pins and the audio/visual intensity consumers, and replaces the single-channel, fixed-depth sensor path.

---
 rtl/distance_array.sv | 193 +++++++++++++++++++
 tb/tb_distance_array.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_array.sv
// Round-robin multi-channel ultrasonic ranging front end with per-channel running
// average and 4-bit proximity intensity.
module distance_array #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned PRESCALE    = 2320,
    parameter int unsigned TRIG_CYC    = 400,
    parameter int unsigned PERIOD_CYC  = 2400000,
    parameter int unsigned TIMEOUT_CYC = 1600000,
    parameter int unsigned INT_SHIFT   = 4,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH-1:0]        echo_i,
    output logic [N_CH-1:0]        trig_o,
    output logic [N_CH*CNT_W-1:0]  avg_dist_o,
    output logic [N_CH*4-1:0]      intensity_o,
    output logic [N_CH-1:0]        valid_o,
    output logic [N_CH-1:0]        timeout_o,
    output logic                   sample_stb_o,
    output logic [CH_W-1:0]        sample_ch_o
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned WP_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned PC_W   = $clog2(PERIOD_CYC);
    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {StTrig, StWaitRise, StMeasure, StUpdate, StGap} state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PS_W-1:0]       presc_q, presc_d;
    logic [CNT_W-1:0]      tick_q, tick_d;
    logic [CNT_W-1:0]      sample_q, sample_d;
    logic                  to_pend_q, to_pend_d;
    logic [N_CH-1:0]       trig_q, trig_d;
    logic [N_CH-1:0]       echo_s1_q, echo_s2_q, echo_s3_q;
    logic                  echo_rise, echo_fall;

    logic [SUM_W-1:0]      sum_q  [N_CH];
    logic [CNT_W-1:0]      buf_q  [N_CH][DEPTH];
    logic [WP_W-1:0]       wp_q   [N_CH];
    logic [FILL_W-1:0]     fill_q [N_CH];
    logic [N_CH-1:0]       timeout_q;
    logic                  stb_q;
    logic [CH_W-1:0]       stb_ch_q;
    logic [SUM_W-1:0]      upd_sum;
    logic [CNT_W-1:0]      old_smp;

    // s3 keeps tracking while idle so a level already high at WAIT_RISE is not an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            echo_s3_q <= '0;
        end else begin
            echo_s1_q <= echo_i;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    assign echo_rise = echo_s2_q[ch_q] & ~echo_s3_q[ch_q];
    assign echo_fall = ~echo_s2_q[ch_q] & echo_s3_q[ch_q];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pc_d      = pc_q + 1'b1;
        presc_d   = presc_q;
        tick_d    = tick_q;
        sample_d  = sample_q;
        to_pend_d = to_pend_q;
        trig_d    = '0;
        unique case (state_q)
            StTrig: begin
                trig_d[ch_q] = 1'b1;
                if (pc_q == PC_W'(TRIG_CYC - 1)) state_d = StWaitRise;
            end
            StWaitRise: begin
                if (echo_rise) begin
                    presc_d = '0;
                    tick_d  = '0;
                    state_d = StMeasure;
                end else if (pc_q == PC_W'(TIMEOUT_CYC)) begin
                    sample_d  = '1;
                    to_pend_d = 1'b1;
                    state_d   = StUpdate;
                end
            end
            StMeasure: begin
                if (presc_q == PS_W'(PRESCALE - 1)) begin
                    presc_d = '0;
                    if (tick_q != '1) tick_d = tick_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // Fall cycle itself is counted, so ticks = floor(high_cycles / PRESCALE)
                if (echo_fall) begin
                    sample_d  = tick_d;
                    to_pend_d = 1'b0;
                    state_d   = StUpdate;
                end else if (pc_q == PC_W'(TIMEOUT_CYC)) begin
                    sample_d  = '1;
                    to_pend_d = 1'b1;
                    state_d   = StUpdate;
                end
            end
            StUpdate: state_d = StGap;
            StGap: begin
                if (pc_q == PC_W'(PERIOD_CYC - 1)) begin
                    pc_d    = '0;
                    state_d = StTrig;
                    ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                end
            end
            default: state_d = StTrig;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StTrig;
            ch_q      <= '0;
            pc_q      <= '0;
            presc_q   <= '0;
            tick_q    <= '0;
            sample_q  <= '0;
            to_pend_q <= 1'b0;
            trig_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pc_q      <= pc_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            sample_q  <= sample_d;
            to_pend_q <= to_pend_d;
            trig_q    <= trig_d;
        end
    end

    assign old_smp = buf_q[ch_q][wp_q[ch_q]];
    assign upd_sum = sum_q[ch_q] + SUM_W'(sample_q) - SUM_W'(old_smp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_CH; k++) begin
                sum_q[k]  <= '0;
                wp_q[k]   <= '0;
                fill_q[k] <= '0;
                for (int d = 0; d < DEPTH; d++) buf_q[k][d] <= '0;
            end
            timeout_q <= '0;
            stb_q     <= 1'b0;
            stb_ch_q  <= '0;
        end else begin
            stb_q <= (state_q == StUpdate);
            if (state_q == StUpdate) begin
                sum_q[ch_q]              <= upd_sum;
                buf_q[ch_q][wp_q[ch_q]]  <= sample_q;
                wp_q[ch_q]               <= (wp_q[ch_q] == WP_W'(DEPTH - 1)) ? '0
                                                                            : wp_q[ch_q] + 1'b1;
                if (fill_q[ch_q] != FILL_W'(DEPTH)) fill_q[ch_q] <= fill_q[ch_q] + 1'b1;
                timeout_q[ch_q]          <= to_pend_q;
                stb_ch_q                 <= ch_q;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        logic [CNT_W-1:0] avg;
        logic [CNT_W-1:0] level;
        assign avg        = CNT_W'(sum_q[k] >> AVG_LOG2);
        assign level      = avg >> INT_SHIFT;
        assign valid_o[k] = (fill_q[k] == FILL_W'(DEPTH));
        assign avg_dist_o[k*CNT_W +: CNT_W] = avg;
        assign intensity_o[4*k +: 4] = (!valid_o[k] || level > CNT_W'(15)) ? 4'd0
                                                                          : 4'(CNT_W'(15) - level);
    end

    assign trig_o       = trig_q;
    assign timeout_o    = timeout_q;
    assign sample_stb_o = stb_q;
    assign sample_ch_o  = stb_ch_q;

endmodule

// File: tb/tb_distance_array.sv
// Bench for distance_array: directed turn table, randomized turns against a
// queue-based running-average model, and reset corner cases.
module tb_distance_array;

    localparam int N_CH        = 2;
    localparam int CNT_W       = 8;
    localparam int AVG_LOG2    = 2;
    localparam int PRESCALE    = 10;
    localparam int TRIG_CYC    = 4;
    localparam int PERIOD_CYC  = 2000;
    localparam int TIMEOUT_CYC = 1500;
    localparam int INT_SHIFT   = 4;
    localparam int DEPTH       = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH-1:0]       echo = '0;
    logic [N_CH-1:0]       trig;
    logic [N_CH*CNT_W-1:0] avg_dist;
    logic [N_CH*4-1:0]     intensity;
    logic [N_CH-1:0]       valid;
    logic [N_CH-1:0]       timeout;
    logic                  sample_stb;
    logic [0:0]            sample_ch;

    distance_array #(
        .N_CH(N_CH), .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .PRESCALE(PRESCALE),
        .TRIG_CYC(TRIG_CYC), .PERIOD_CYC(PERIOD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
        .INT_SHIFT(INT_SHIFT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .echo_i(echo), .trig_o(trig), .avg_dist_o(avg_dist),
        .intensity_o(intensity), .valid_o(valid), .timeout_o(timeout),
        .sample_stb_o(sample_stb), .sample_ch_o(sample_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int stb_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_turns = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sample_stb) stb_cnt <= stb_cnt + 1;

    // mode: 0 = echo pulse of h cycles, 1 = no echo, 2 = echo pre-asserted until cycle 1600
    typedef struct {
        int ch; int mode; int h; int dly;
        int e_avg; int e_int; int e_valid; int e_to;
    } vec_t;
    vec_t tbl[22];

    int hist[2][$];
    int mfill[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            repeat (DEPTH) hist[c].push_back(0);
            mfill[c] = 0;
        end
    endtask

    task automatic model_push(input int c, input int s);
        hist[c].push_back(s);
        void'(hist[c].pop_front());
        if (mfill[c] < DEPTH) mfill[c]++;
    endtask

    function automatic int model_avg(input int c);
        int s = 0;
        for (int i = 0; i < hist[c].size(); i++) s += hist[c][i];
        return s / DEPTH;
    endfunction

    function automatic int model_int(input int c);
        int lvl;
        if (mfill[c] < DEPTH) return 0;
        lvl = model_avg(c) / 16;
        return (lvl > 15) ? 0 : 15 - lvl;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got none, expected event", name);
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, " trig"}, int'(trig), 0);
        chk({p, " avg_dist"}, int'(avg_dist), 0);
        chk({p, " intensity"}, int'(intensity), 0);
        chk({p, " valid"}, int'(valid), 0);
        chk({p, " timeout"}, int'(timeout), 0);
        chk({p, " sample_stb"}, int'(sample_stb), 0);
        chk({p, " sample_ch"}, int'(sample_ch), 0);
    endtask

    // One channel turn; expected values of -1 mean "take them from the model"
    task automatic run_turn(input int idx, input int ch, input int mode, input int h,
                            input int dly, input int e_avg, input int e_int,
                            input int e_valid, input int e_to, output int t_rise);
        int  t_stb, w, s, ea, ei, ev, et;
        bit  seen;
        if (mode == 2) echo[ch] = 1'b1;
        t_rise = cyc;
        seen = 0;
        for (int n = 0; n < 4500; n++) begin
            @(negedge clk);
            if (trig[ch]) begin seen = 1; break; end
        end
        if (!seen) begin bound_fail($sformatf("t%0d trig_rise", idx)); return; end
        t_rise = cyc;
        chk($sformatf("t%0d trig_onehot", idx), int'(trig), 1 << ch);
        w = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (trig[ch]) w++; else break;
        end
        chk($sformatf("t%0d trig_width", idx), w, TRIG_CYC);
        if (mode == 0) begin
            repeat (dly) @(negedge clk);
            echo[ch] = 1'b1;
            repeat (h) @(negedge clk);
            echo[ch] = 1'b0;
        end
        seen = 0;
        for (int n = 0; n < 3000; n++) begin
            if (sample_stb) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) begin bound_fail($sformatf("t%0d strobe", idx)); return; end
        t_stb = cyc;
        n_turns++;
        s = (mode == 0) ? ((h / PRESCALE > 255) ? 255 : h / PRESCALE) : 255;
        model_push(ch, s);
        ea = (e_avg   >= 0) ? e_avg   : model_avg(ch);
        ei = (e_int   >= 0) ? e_int   : model_int(ch);
        ev = (e_valid >= 0) ? e_valid : int'(mfill[ch] == DEPTH);
        et = (e_to    >= 0) ? e_to    : int'(mode != 0);
        chk($sformatf("t%0d sample_ch", idx), int'(sample_ch), ch);
        chk($sformatf("t%0d avg", idx), int'(avg_dist[ch*CNT_W +: CNT_W]), ea);
        chk($sformatf("t%0d intensity", idx), int'(intensity[4*ch +: 4]), ei);
        chk($sformatf("t%0d valid", idx), int'(valid[ch]), ev);
        chk($sformatf("t%0d timeout", idx), int'(timeout[ch]), et);
        if (mode != 0) chk($sformatf("t%0d to_latency", idx), t_stb - t_rise, TIMEOUT_CYC + 1);
        if (mode == 2) begin
            while (cyc - t_rise < 1600) @(negedge clk);
            echo[ch] = 1'b0;
        end
    endtask

    initial begin
        #(1_500_000 * 10);
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, tr, cnt0, mode, h, dly;
        int rise[22];
        bit seen;

        tbl[0]  = '{0, 0, 100,  3,   2,  0, 0, 0};
        tbl[1]  = '{1, 1,   0,  0,  63,  0, 0, 1};
        tbl[2]  = '{0, 0, 100, 10,   5,  0, 0, 0};
        tbl[3]  = '{1, 1,   0,  0, 127,  0, 0, 1};
        tbl[4]  = '{0, 0, 100,  0,   7,  0, 0, 0};
        tbl[5]  = '{1, 1,   0,  0, 191,  0, 0, 1};
        tbl[6]  = '{0, 0, 100, 20,  10, 15, 1, 0};
        tbl[7]  = '{1, 1,   0,  0, 255,  0, 1, 1};
        tbl[8]  = '{0, 0, 400,  5,  17, 14, 1, 0};
        tbl[9]  = '{1, 0, 250,  7, 197,  3, 1, 0};
        tbl[10] = '{0, 0, 400,  1,  25, 14, 1, 0};
        tbl[11] = '{1, 0, 500, 12, 146,  6, 1, 0};
        tbl[12] = '{0, 0, 400,  2,  32, 13, 1, 0};
        tbl[13] = '{1, 0,1000,  4, 107,  9, 1, 0};
        tbl[14] = '{0, 0, 400,  9,  40, 13, 1, 0};
        tbl[15] = '{1, 0,  55,  3,  45, 13, 1, 0};
        tbl[16] = '{0, 0, 800,  6,  50, 12, 1, 0};
        tbl[17] = '{1, 1,   0,  0, 102,  9, 1, 1};
        tbl[18] = '{0, 2,   0,  0, 103,  9, 1, 1};
        tbl[19] = '{1, 0, 123,  8,  93, 10, 1, 0};
        tbl[20] = '{0, 0, 300, 11, 101,  9, 1, 0};
        tbl[21] = '{1, 0,   9,  2,  68, 11, 1, 0};

        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rel = cyc;
        rst_n = 1'b1;

        for (int t = 0; t < 22; t++) begin
            run_turn(t, tbl[t].ch, tbl[t].mode, tbl[t].h, tbl[t].dly, tbl[t].e_avg,
                     tbl[t].e_int, tbl[t].e_valid, tbl[t].e_to, tr);
            rise[t] = tr;
        end
        chk("trig0_first_edge", rise[0] - rel, 1);
        chk("trig1_period", rise[1] - rise[0], PERIOD_CYC);
        chk("trig0_second", rise[2] - rise[0], 2 * PERIOD_CYC);

        for (int t = 22; t < 32; t++) begin
            mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            h    = $urandom_range(1, 1300);
            dly  = $urandom_range(0, 60);
            run_turn(t, t % 2, mode, h, dly, -1, -1, -1, -1, tr);
        end

        seen = 0;
        for (int n = 0; n < 4500; n++) begin
            @(negedge clk);
            if (trig[0]) begin seen = 1; break; end
        end
        if (!seen) bound_fail("rst_mid trig_rise");
        repeat (10) @(negedge clk);
        echo[0] = 1'b1;
        repeat (50) @(negedge clk);
        cnt0 = stb_cnt;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        echo[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid no_strobe", stb_cnt, cnt0);
        model_reset();
        rel = cyc;
        rst_n = 1'b1;
        run_turn(40, 0, 0, 200, 5, 5, 0, 0, 0, tr);
        chk("rst_mid trig_restart", tr - rel, 1);

        @(negedge clk);
        chk("strobe_count", stb_cnt, n_turns);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
